// File: rtl/pcie_link_mon_pkg.sv
// Shared LTSSM encodings, link FSM states and LED polarity for the PCIe link status monitor.
package pcie_link_mon_pkg;

    localparam logic [4:0] L0              = 5'h0F;
    localparam logic [4:0] POLL_COMPLIANCE = 5'h03;

    // Board LEDs are wired active-low.
    localparam logic LED_ON = 1'b0;

    typedef enum logic [1:0] {
        DOWN    = 2'd0,
        QUALIFY = 2'd1,
        UP      = 2'd2,
        LOST    = 2'd3
    } link_state_e;

endpackage

// File: rtl/pcie_rst_sync.sv
// Two-flop reset synchronizer: asserts immediately, releases two clocks after any_rstn rises.
module pcie_rst_sync (
    input  logic clk_out_buf,
    input  logic any_rstn,
    output logic rst_rr
);

    logic rst_r;

    always_ff @(posedge clk_out_buf or negedge any_rstn) begin
        if (!any_rstn) begin
            rst_r  <= 1'b0;
            rst_rr <= 1'b0;
        end else begin
            rst_r  <= 1'b1;
            rst_rr <= rst_r;
        end
    end

endmodule

// File: rtl/pcie_link_status_monitor.sv
// Qualifies PCIe link-up from the LTSSM test bus, counts link drops and drives the board status LEDs.
module pcie_link_status_monitor
    import pcie_link_mon_pkg::*;
#(
    parameter int STABLE_CYCLES  = 1024,
    parameter int HOLDOFF_CYCLES = 256,
    parameter int ALIVE_W        = 26,
    parameter int CNT_W          = 8
) (
    input  logic             clk_out_buf,
    input  logic             any_rstn,
    input  logic [8:0]       test_out_icm,
    input  logic             gen2_speed,
    input  logic             cnt_clr,
    output logic             link_up,
    output logic             link_down_pulse,
    output logic [CNT_W-1:0] retrain_cnt,
    output logic [4:0]       ltssm_state,
    output logic             alive_led,
    output logic             L0_led,
    output logic             comp_led,
    output logic             gen2_led,
    output logic [3:0]       lane_active_led,
    output link_state_e      fsm_state
);

    localparam int QW = $clog2(STABLE_CYCLES);
    localparam int HW = $clog2(HOLDOFF_CYCLES + 1);

    logic               rst_rr;
    logic [4:0]         ltssm_q;
    logic [3:0]         lane_q;
    logic               gen2_q;
    logic [ALIVE_W-1:0] alive_cnt;
    logic [QW-1:0]      qcnt;
    logic [HW-1:0]      hcnt;
    link_state_e        state;

    pcie_rst_sync u_rst_sync (
        .clk_out_buf (clk_out_buf),
        .any_rstn    (any_rstn),
        .rst_rr      (rst_rr)
    );

    assign ltssm_state = ltssm_q;
    assign fsm_state   = state;

    // Input capture, LED drivers and heartbeat; LEDs trail ltssm_q/link_up by one clock.
    always_ff @(posedge clk_out_buf or negedge rst_rr) begin
        if (!rst_rr) begin
            ltssm_q         <= '0;
            lane_q          <= '0;
            gen2_q          <= 1'b0;
            L0_led          <= ~LED_ON;
            comp_led        <= ~LED_ON;
            gen2_led        <= ~LED_ON;
            lane_active_led <= {4{~LED_ON}};
            alive_cnt       <= '0;
            alive_led       <= 1'b0;
        end else begin
            ltssm_q         <= test_out_icm[4:0];
            lane_q          <= test_out_icm[8:5];
            gen2_q          <= gen2_speed;
            L0_led          <= link_up ? LED_ON : ~LED_ON;
            comp_led        <= (ltssm_q == POLL_COMPLIANCE) ? LED_ON : ~LED_ON;
            gen2_led        <= (gen2_q && link_up) ? LED_ON : ~LED_ON;
            lane_active_led <= lane_q ^ {4{~LED_ON}};
            alive_cnt       <= alive_cnt + ALIVE_W'(1);
            alive_led       <= alive_cnt[ALIVE_W-1];
        end
    end

    always_ff @(posedge clk_out_buf or negedge rst_rr) begin
        if (!rst_rr) begin
            state           <= DOWN;
            qcnt            <= '0;
            hcnt            <= '0;
            link_up         <= 1'b0;
            link_down_pulse <= 1'b0;
            retrain_cnt     <= '0;
        end else begin
            link_down_pulse <= 1'b0;
            if (cnt_clr) begin
                retrain_cnt <= '0;
            end
            case (state)
                DOWN: begin
                    if (ltssm_q == L0) begin
                        state <= QUALIFY;
                        qcnt  <= QW'(1);
                    end
                end
                QUALIFY: begin
                    if (ltssm_q != L0) begin
                        state <= DOWN;
                    end else if (qcnt == QW'(STABLE_CYCLES - 1)) begin
                        state   <= UP;
                        link_up <= 1'b1;
                    end else begin
                        qcnt <= qcnt + QW'(1);
                    end
                end
                UP: begin
                    if (ltssm_q != L0) begin
                        state           <= LOST;
                        link_up         <= 1'b0;
                        hcnt            <= '0;
                        link_down_pulse <= 1'b1;
                        // A clear in the same cycle wins over the increment.
                        if (!cnt_clr && retrain_cnt != {CNT_W{1'b1}}) begin
                            retrain_cnt <= retrain_cnt + CNT_W'(1);
                        end
                    end
                end
                LOST: begin
                    // LTSSM deliberately ignored until the holdoff expires.
                    if (hcnt == HW'(HOLDOFF_CYCLES - 1)) begin
                        state <= DOWN;
                    end else begin
                        hcnt <= hcnt + HW'(1);
                    end
                end
                default: state <= DOWN;
            endcase
        end
    end

endmodule

// File: tb/tb_pcie_link_status_monitor.sv
// Directed scoreboard bench for pcie_link_status_monitor with small qualify/holdoff/counter sizes.
module tb_pcie_link_status_monitor;
    import pcie_link_mon_pkg::*;

    localparam int STABLE_CYCLES  = 4;
    localparam int HOLDOFF_CYCLES = 2;
    localparam int ALIVE_W        = 4;
    localparam int CNT_W          = 2;

    localparam logic [3:0] S_LINK  = 4'd0;
    localparam logic [3:0] S_PULSE = 4'd1;
    localparam logic [3:0] S_RCNT  = 4'd2;
    localparam logic [3:0] S_LTSSM = 4'd3;
    localparam logic [3:0] S_ALIVE = 4'd4;
    localparam logic [3:0] S_L0LED = 4'd5;
    localparam logic [3:0] S_COMP  = 4'd6;
    localparam logic [3:0] S_GEN2  = 4'd7;
    localparam logic [3:0] S_LANE  = 4'd8;
    localparam logic [3:0] S_STATE = 4'd9;

    typedef struct packed {
        int         cyc;
        logic [3:0] sel;
        logic [7:0] val;
    } chk_t;

    logic             clk;
    logic             any_rstn;
    logic [8:0]       test_out_icm;
    logic             gen2_speed;
    logic             cnt_clr;
    logic             link_up;
    logic             link_down_pulse;
    logic [CNT_W-1:0] retrain_cnt;
    logic [4:0]       ltssm_state;
    logic             alive_led;
    logic             L0_led;
    logic             comp_led;
    logic             gen2_led;
    logic [3:0]       lane_active_led;
    link_state_e      fsm_state;

    chk_t exp_q[$];
    chk_t pulse_q[$];
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    pcie_link_status_monitor #(
        .STABLE_CYCLES  (STABLE_CYCLES),
        .HOLDOFF_CYCLES (HOLDOFF_CYCLES),
        .ALIVE_W        (ALIVE_W),
        .CNT_W          (CNT_W)
    ) dut (
        .clk_out_buf     (clk),
        .any_rstn        (any_rstn),
        .test_out_icm    (test_out_icm),
        .gen2_speed      (gen2_speed),
        .cnt_clr         (cnt_clr),
        .link_up         (link_up),
        .link_down_pulse (link_down_pulse),
        .retrain_cnt     (retrain_cnt),
        .ltssm_state     (ltssm_state),
        .alive_led       (alive_led),
        .L0_led          (L0_led),
        .comp_led        (comp_led),
        .gen2_led        (gen2_led),
        .lane_active_led (lane_active_led),
        .fsm_state       (fsm_state)
    );

    // Clock / cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] actual(input logic [3:0] sel);
        case (sel)
            S_LINK:  return {7'd0, link_up};
            S_PULSE: return {7'd0, link_down_pulse};
            S_RCNT:  return {6'd0, retrain_cnt};
            S_LTSSM: return {3'd0, ltssm_state};
            S_ALIVE: return {7'd0, alive_led};
            S_L0LED: return {7'd0, L0_led};
            S_COMP:  return {7'd0, comp_led};
            S_GEN2:  return {7'd0, gen2_led};
            S_LANE:  return {4'd0, lane_active_led};
            S_STATE: return {6'd0, fsm_state};
            default: return 8'd0;
        endcase
    endfunction

    function automatic string sel_name(input logic [3:0] sel);
        case (sel)
            S_LINK:  return "link_up";
            S_PULSE: return "link_down_pulse";
            S_RCNT:  return "retrain_cnt";
            S_LTSSM: return "ltssm_state";
            S_ALIVE: return "alive_led";
            S_L0LED: return "L0_led";
            S_COMP:  return "comp_led";
            S_GEN2:  return "gen2_led";
            S_LANE:  return "lane_active_led";
            S_STATE: return "fsm_state";
            default: return "unknown";
        endcase
    endfunction

    // Driver tasks: all called at a negedge; expectations are tagged with the negedge they apply to.
    task automatic expect_at(input int dc, input logic [3:0] sel, input logic [7:0] val);
        exp_q.push_back('{cyc: cyc + dc, sel: sel, val: val});
    endtask

    task automatic pulse_push(input int dc, input logic [7:0] cnt);
        pulse_q.push_back('{cyc: cyc + dc, sel: S_PULSE, val: cnt});
    endtask

    task automatic set_ltssm(input logic [4:0] v);
        test_out_icm[4:0] = v;
    endtask

    task automatic drop(input logic [7:0] exp_cnt);
        set_ltssm(5'h0D);
        pulse_push(2, exp_cnt);
        expect_at(2, S_LINK, 8'd0);
        expect_at(3, S_RCNT, exp_cnt);
        expect_at(4, S_STATE, 8'(DOWN));
        @(negedge clk);
        set_ltssm(5'h0C);
        repeat (5) @(negedge clk);
    endtask

    task automatic qualify();
        set_ltssm(L0);
        expect_at(4, S_LINK, 8'd0);
        expect_at(5, S_LINK, 8'd1);
        expect_at(6, S_L0LED, 8'd0);
        repeat (7) @(negedge clk);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        chk_t p;
        logic [7:0] a;
        if (link_down_pulse) begin
            if (pulse_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL pulse_unexpected cycle=%0d actual=1 required=0", cyc);
            end else begin
                p = pulse_q.pop_front();
                total++;
                if (p.cyc != cyc) begin
                    bad++;
                    $display("FAIL pulse_cycle actual=%0d required=%0d", cyc, p.cyc);
                end
                total++;
                if ({6'd0, retrain_cnt} != p.val) begin
                    bad++;
                    $display("FAIL pulse_retrain_cnt cycle=%0d actual=%0d required=%0d", cyc, retrain_cnt, p.val);
                end
            end
        end
        for (int i = exp_q.size() - 1; i >= 0; i--) begin
            if (exp_q[i].cyc == cyc) begin
                a = actual(exp_q[i].sel);
                total++;
                if (a != exp_q[i].val) begin
                    bad++;
                    $display("FAIL %s cycle=%0d actual=0x%0h required=0x%0h",
                             sel_name(exp_q[i].sel), cyc, a, exp_q[i].val);
                end
                exp_q.delete(i);
            end
        end
    end

    initial begin
        any_rstn     = 1'b0;
        test_out_icm = {4'b0000, L0};
        gen2_speed   = 1'b0;
        cnt_clr      = 1'b0;
        repeat (3) @(negedge clk);

        // Reset values
        expect_at(1, S_LINK, 8'd0);
        expect_at(1, S_PULSE, 8'd0);
        expect_at(1, S_RCNT, 8'd0);
        expect_at(1, S_LTSSM, 8'd0);
        expect_at(1, S_ALIVE, 8'd0);
        expect_at(1, S_L0LED, 8'd1);
        expect_at(1, S_COMP, 8'd1);
        expect_at(1, S_GEN2, 8'd1);
        expect_at(1, S_LANE, 8'h0F);
        expect_at(1, S_STATE, 8'(DOWN));
        @(negedge clk);

        // Release with L0 held: link_up 2+1+4 clocks later
        any_rstn = 1'b1;
        expect_at(2, S_LTSSM, 8'd0);
        expect_at(2, S_STATE, 8'(DOWN));
        expect_at(3, S_LTSSM, 8'h0F);
        expect_at(4, S_STATE, 8'(QUALIFY));
        expect_at(6, S_LINK, 8'd0);
        expect_at(7, S_LINK, 8'd1);
        expect_at(7, S_L0LED, 8'd1);
        expect_at(8, S_L0LED, 8'd0);
        repeat (9) @(negedge clk);

        // Drop from UP; LOST holds 2 cycles although L0 returns immediately
        set_ltssm(5'h0D);
        pulse_push(2, 8'd1);
        expect_at(1, S_LINK, 8'd1);
        expect_at(2, S_LINK, 8'd0);
        expect_at(2, S_STATE, 8'(LOST));
        expect_at(3, S_STATE, 8'(LOST));
        expect_at(3, S_RCNT, 8'd1);
        expect_at(3, S_L0LED, 8'd1);
        expect_at(4, S_STATE, 8'(DOWN));
        expect_at(5, S_STATE, 8'(QUALIFY));
        expect_at(7, S_LINK, 8'd0);
        expect_at(8, S_LINK, 8'd1);
        @(negedge clk);
        set_ltssm(L0);
        repeat (9) @(negedge clk);

        // Further drops: counter 2, 3, then saturates at 3
        drop(8'd2);
        qualify();
        drop(8'd3);
        qualify();
        drop(8'd3);

        // L0 glitch during qualification restarts the count
        set_ltssm(L0);
        expect_at(3, S_STATE, 8'(QUALIFY));
        expect_at(4, S_STATE, 8'(QUALIFY));
        expect_at(5, S_STATE, 8'(DOWN));
        expect_at(6, S_STATE, 8'(QUALIFY));
        for (int k = 1; k <= 8; k++) expect_at(k, S_LINK, 8'd0);
        expect_at(9, S_LINK, 8'd1);
        repeat (3) @(negedge clk);
        set_ltssm(5'h0C);
        @(negedge clk);
        set_ltssm(L0);
        repeat (6) @(negedge clk);

        // Fifth drop with cnt_clr on the same edge: clear wins
        set_ltssm(5'h0D);
        pulse_push(2, 8'd0);
        expect_at(1, S_RCNT, 8'd3);
        expect_at(2, S_LINK, 8'd0);
        expect_at(3, S_RCNT, 8'd0);
        @(negedge clk);
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        repeat (4) @(negedge clk);

        // Compliance, gen2 and lane LEDs while link is down
        test_out_icm = {4'b0101, POLL_COMPLIANCE};
        gen2_speed   = 1'b1;
        expect_at(1, S_COMP, 8'd1);
        expect_at(2, S_COMP, 8'd0);
        expect_at(2, S_GEN2, 8'd1);
        expect_at(2, S_LANE, 8'h0A);
        expect_at(2, S_LTSSM, 8'h03);
        expect_at(3, S_STATE, 8'(DOWN));
        repeat (3) @(negedge clk);

        // Requalify at Gen2: gen2_led follows link_up by one clock
        expect_at(2, S_COMP, 8'd1);
        expect_at(5, S_GEN2, 8'd1);
        expect_at(6, S_GEN2, 8'd0);
        qualify();

        // Asynchronous reset mid-UP, then release and watch the heartbeat
        expect_at(1, S_LINK, 8'd0);
        expect_at(1, S_L0LED, 8'd1);
        expect_at(1, S_COMP, 8'd1);
        expect_at(1, S_GEN2, 8'd1);
        expect_at(1, S_LANE, 8'h0F);
        expect_at(1, S_ALIVE, 8'd0);
        expect_at(1, S_LTSSM, 8'd0);
        expect_at(1, S_STATE, 8'(DOWN));
        @(posedge clk);
        #2 any_rstn = 1'b0;
        @(negedge clk);
        @(negedge clk);
        any_rstn = 1'b1;
        expect_at(2, S_STATE, 8'(DOWN));
        expect_at(3, S_LANE, 8'h0F);
        expect_at(4, S_LANE, 8'h0A);
        expect_at(6, S_LINK, 8'd0);
        expect_at(7, S_LINK, 8'd1);
        expect_at(10, S_ALIVE, 8'd0);
        expect_at(11, S_ALIVE, 8'd1);
        expect_at(18, S_ALIVE, 8'd1);
        expect_at(19, S_ALIVE, 8'd0);
        expect_at(27, S_ALIVE, 8'd1);
        repeat (30) @(negedge clk);

        // Final report
        foreach (exp_q[i]) begin
            total++;
            bad++;
            $display("FAIL %s_unchecked cycle=%0d actual=none required=0x%0h",
                     sel_name(exp_q[i].sel), exp_q[i].cyc, exp_q[i].val);
        end
        foreach (pulse_q[i]) begin
            total++;
            bad++;
            $display("FAIL pulse_missing actual=none required_cycle=%0d", pulse_q[i].cyc);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
